// File: rtl/bram_burst_reader.sv
// Burst read client for a block RAM port with a registered output.
// A request {addr, len} is turned into one RAM read per cycle. Each read is
// tracked through a READ_LATENCY-deep pipeline and its word is captured into
// a small output FIFO. A read issues only while reads in flight plus words
// buffered are below FIFO_DEPTH, so back-pressure never drops a word.
//
// Handshakes (request and data stream) use strict valid/ready semantics:
// a transfer happens on a rising clock edge where valid and ready are both
// high. The source holds valid and its payload stable until that edge. Valid
// never depends on ready. req_ready_out is high only in IDLE. data_valid_out
// is high whenever the FIFO holds a word.
module bram_burst_reader #(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int LEN_W        = 11,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2,
  localparam int ADDR_W      = $clog2(RAM_DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [ADDR_W-1:0]    req_addr_in,
  input  logic [LEN_W-1:0]     req_len_in,
  output logic [ADDR_W-1:0]    ram_addr_out,
  output logic                 ram_en_out,
  output logic                 ram_regce_out,
  input  logic [RAM_WIDTH-1:0] ram_dout_in,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 data_last_out,
  output logic                 data_valid_out,
  input  logic                 data_ready_in,
  output logic                 busy_out,
  output logic [1:0]           state_dbg_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [READ_LATENCY-1:0] sr_v_q, sr_v_d;
  logic [READ_LATENCY-1:0] sr_l_q, sr_l_d;

  logic [RAM_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic                    fifo_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;

  logic                    issue, issue_last, capture, pop, fifo_empty;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W:0]          credits_used;

  assign fifo_empty   = (count_q == '0);
  assign pop          = !fifo_empty && data_ready_in;
  assign capture      = sr_v_q[READ_LATENCY-1];
  assign credits_used = {1'b0, inflight} + {1'b0, count_q};

  // Count reads currently travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(sr_v_q[i]);
    end
  end

  // Next-state, address/length bookkeeping and issue decision.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          addr_d = req_addr_in;
          rem_d  = req_len_in;
          if (req_len_in != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (credits_used < DEPTH_C) begin
          issue      = 1'b1;
          issue_last = (rem_q == LEN_W'(1));
          rem_d      = rem_q - LEN_W'(1);
          addr_d     = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_W'(1);
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the edge where the final beat is taken, so a new request
        // can be accepted on the very next edge.
        if ((pop && fifo_last_q[rd_ptr_q]) || (fifo_empty && inflight == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift {valid, last} along with each read until its data returns.
  always_comb begin
    sr_v_d    = sr_v_q;
    sr_l_d    = sr_l_q;
    sr_v_d[0] = issue;
    sr_l_d[0] = issue_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      sr_v_d[i] = sr_v_q[i-1];
      sr_l_d[i] = sr_l_q[i-1];
    end
  end

  // Control state registers; reset abandons any burst and its returns.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sr_v_q  <= '0;
      sr_l_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sr_v_q  <= sr_v_d;
      sr_l_q  <= sr_l_d;
    end
  end

  // Output FIFO: capture returning words, pop on stream handshake.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (capture) begin
        fifo_data_q[wr_ptr_q] <= ram_dout_in;
        fifo_last_q[wr_ptr_q] <= sr_l_q[READ_LATENCY-1];
        wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({capture, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign req_ready_out  = (state_q == IDLE);
  assign busy_out       = (state_q != IDLE);
  assign state_dbg_out  = state_q;
  assign ram_en_out     = issue;
  assign ram_addr_out   = addr_q;
  assign ram_regce_out  = 1'b1;
  assign data_valid_out = !fifo_empty;
  assign data_out       = fifo_data_q[rd_ptr_q];
  assign data_last_out  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: a behavioural 2-cycle registered-output RAM
// holding RAM[i] = i+100, a table of bursts, and hand-written sequences for
// latency, len=0, asynchronous reset mid-burst and back-to-back requests.
module tb_bram_burst_reader;

  localparam int RAM_WIDTH  = 18;
  localparam int RAM_DEPTH  = 1024;
  localparam int ADDR_W     = 10;
  localparam int LEN_W      = 11;
  localparam int FIFO_DEPTH = 4;
  localparam int W          = RAM_WIDTH + 1;

  typedef struct {
    int addr;
    int len;
    int stall_at;
    int stall_cyc;
    int exp_first;
    int exp_last;
  } burst_vec_t;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in = 1'b0;
  logic                 req_valid_in = 1'b0;
  logic                 req_ready_out;
  logic [ADDR_W-1:0]    req_addr_in = '0;
  logic [LEN_W-1:0]     req_len_in = '0;
  logic [ADDR_W-1:0]    ram_addr_out;
  logic                 ram_en_out;
  logic                 ram_regce_out;
  logic [RAM_WIDTH-1:0] ram_dout_in;
  logic [RAM_WIDTH-1:0] data_out;
  logic                 data_last_out;
  logic                 data_valid_out;
  logic                 data_ready_in = 1'b1;
  logic                 busy_out;
  logic [1:0]           state_dbg;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_r1;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int beat_cnt = 0;
  int issued_cnt = 0;
  int popped_cnt = 0;
  int last_hs_edge = 0;
  logic [RAM_WIDTH-1:0] first_word, last_word;
  logic seen_first = 1'b0;
  logic mon_prev_stall = 1'b0;
  logic [W-1:0] mon_prev_beat;
  burst_vec_t vecs[5];

  bram_burst_reader dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_addr_in    (req_addr_in),
    .req_len_in     (req_len_in),
    .ram_addr_out   (ram_addr_out),
    .ram_en_out     (ram_en_out),
    .ram_regce_out  (ram_regce_out),
    .ram_dout_in    (ram_dout_in),
    .data_out       (data_out),
    .data_last_out  (data_last_out),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .busy_out       (busy_out),
    .state_dbg_out  (state_dbg)
  );

  // Clock and edge counter.
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM port model: address register then output register.
  always @(posedge clk_in) begin
    if (ram_en_out) ram_r1 <= mem[ram_addr_out];
    if (ram_regce_out) ram_dout_in <= ram_r1;
  end

  // Monitor on the falling edge: read addresses, credit bound, stream beats.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (ram_en_out) begin
        n_vec++;
        if (issued_cnt - popped_cnt >= FIFO_DEPTH) begin
          n_err++;
          $display("FAIL credit: outstanding=%0d required <%0d", issued_cnt - popped_cnt, FIFO_DEPTH);
        end
        n_vec++;
        if (exp_addr_q.size() == 0) begin
          n_err++;
          $display("FAIL ram_addr: unexpected read at %0d", ram_addr_out);
        end else begin
          logic [ADDR_W-1:0] ea;
          ea = exp_addr_q.pop_front();
          if (ram_addr_out !== ea) begin
            n_err++;
            $display("FAIL ram_addr: got %0d expected %0d", ram_addr_out, ea);
          end
        end
        issued_cnt++;
      end
      if (mon_prev_stall) begin
        n_vec++;
        if (!data_valid_out || {data_last_out, data_out} !== mon_prev_beat) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h", data_valid_out,
                   {data_last_out, data_out}, mon_prev_beat);
        end
      end
      if (data_valid_out && data_ready_in) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected word %0d last=%0b", data_out, data_last_out);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({data_last_out, data_out} !== e) begin
            n_err++;
            $display("FAIL beat: got last=%0b data=%0d expected last=%0b data=%0d",
                     data_last_out, data_out, e[W-1], e[RAM_WIDTH-1:0]);
          end
        end
        if (!seen_first) first_word = data_out;
        seen_first = 1'b1;
        last_word  = data_out;
        if (data_last_out) last_hs_edge = cyc + 1;
        popped_cnt++;
        beat_cnt++;
      end
      mon_prev_stall = data_valid_out && !data_ready_in;
      mon_prev_beat  = {data_last_out, data_out};
    end else begin
      mon_prev_stall = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_burst(input int addr, input int len);
    for (int k = 0; k < len; k++) begin
      int a;
      a = (addr + k) % RAM_DEPTH;
      exp_q.push_back({(k == len - 1), RAM_WIDTH'(a + 100)});
      exp_addr_q.push_back(ADDR_W'(a));
    end
  endtask

  task automatic send_req(input int addr, input int len, output int acc_edge);
    int guard;
    guard = 0;
    while (!req_ready_out && guard < 200) begin
      tick();
      guard++;
    end
    check("req_ready_wait", req_ready_out, 1);
    req_valid_in = 1'b1;
    req_addr_in  = ADDR_W'(addr);
    req_len_in   = LEN_W'(len);
    tick();
    acc_edge     = cyc;
    req_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy_out || data_valid_out || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  task automatic run_burst(input burst_vec_t v);
    int acc, stall_left, n, start;
    push_burst(v.addr, v.len);
    seen_first    = 1'b0;
    start         = beat_cnt;
    stall_left    = v.stall_cyc;
    data_ready_in = !(v.stall_at == 0 && v.stall_cyc > 0);
    send_req(v.addr, v.len, acc);
    n = 0;
    while ((busy_out || data_valid_out) && n < 300) begin
      if (beat_cnt - start >= v.stall_at && stall_left > 0) begin
        data_ready_in = 1'b0;
        stall_left--;
      end else begin
        data_ready_in = 1'b1;
      end
      tick();
      n++;
    end
    data_ready_in = 1'b1;
    check("burst_done", (n < 300), 1);
    check("burst_beats", beat_cnt - start, v.len);
    check("burst_first", first_word, v.exp_first);
    check("burst_last", last_word, v.exp_last);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Main stimulus.
  initial begin
    int acc, acc2, start;
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = RAM_WIDTH'(i + 100);
    vecs[0] = '{10,   4, 99, 0, 110,  113};
    vecs[1] = '{10,   4, 1,  6, 110,  113};
    vecs[2] = '{1022, 4, 99, 0, 1122, 101};
    vecs[3] = '{300,  8, 0,  8, 400,  407};
    vecs[4] = '{1020, 6, 2,  3, 1120, 101};

    // Reset values while reset is held.
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_req_ready", req_ready_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_ram_en", ram_en_out, 0);
    check("rst_ram_addr", ram_addr_out, 0);
    check("rst_regce", ram_regce_out, 1);
    check("rst_valid", data_valid_out, 0);
    check("rst_last", data_last_out, 0);
    check("rst_data", data_out, 0);
    rst_n_in = 1'b1;
    tick();

    // Latency: first issue in the cycle after accept, first valid 3 edges later.
    data_ready_in = 1'b1;
    push_burst(10, 4);
    send_req(10, 4, acc);
    check("lat_ram_en", ram_en_out, 1);
    check("lat_ram_addr", ram_addr_out, 10);
    check("lat_valid_e0", data_valid_out, 0);
    tick();
    check("lat_valid_e1", data_valid_out, 0);
    tick();
    check("lat_valid_e2", data_valid_out, 0);
    tick();
    check("lat_valid_e3", data_valid_out, 1);
    check("lat_data_e3", data_out, 110);
    wait_idle("lat_idle", 100);

    // Table of bursts.
    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // len=0: accepted, nothing happens.
    send_req(50, 0, acc);
    for (int i = 0; i < 6; i++) begin
      check("len0_busy", busy_out, 0);
      check("len0_ram_en", ram_en_out, 0);
      check("len0_valid", data_valid_out, 0);
      tick();
    end
    check("len0_ready", req_ready_out, 1);

    // Asynchronous reset after 2 of 8 beats.
    push_burst(20, 8);
    start = beat_cnt;
    send_req(20, 8, acc);
    for (int n = 0; n < 100 && beat_cnt - start < 2; n++) tick();
    check("mid_beats", beat_cnt - start, 2);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready_out, 1);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_ram_en", ram_en_out, 0);
    check("mid_rst_ram_addr", ram_addr_out, 0);
    check("mid_rst_valid", data_valid_out, 0);
    check("mid_rst_last", data_last_out, 0);
    check("mid_rst_data", data_out, 0);
    exp_q.delete();
    exp_addr_q.delete();
    issued_cnt = 0;
    popped_cnt = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    tick();
    run_burst('{0, 2, 99, 0, 100, 101});

    // Back-to-back bursts with the second accepted right after the last beat.
    data_ready_in = 1'b1;
    start = beat_cnt;
    push_burst(5, 3);
    send_req(5, 3, acc);
    push_burst(200, 2);
    send_req(200, 2, acc2);
    check("b2b_accept_edge", acc2, last_hs_edge + 1);
    wait_idle("b2b_idle", 100);
    check("b2b_beats", beat_cnt - start, 5);
    check("b2b_last_word", last_word, 301);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_addr_q_empty", exp_addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_burst_reader.md
# bram_burst_reader

Read-side client for the team's dual-port block RAM, configured with a registered output (2-cycle read latency). It accepts a burst request (start address, word count) and issues one RAM read per cycle on one RAM port. Returned words go out on a valid/ready stream with a last-beat flag. Downstream back-pressure is absorbed by a small credit-controlled output FIFO, so no returning word is ever dropped. Typical consumers are the frame/sample streaming paths that sit between BRAM and display or audio output logic.

## Interface
- RAM_WIDTH, 18: data word width; matches the RAM instance.
- RAM_DEPTH, 1024: RAM entries; ADDR_W = clog2(RAM_DEPTH).
- READ_LATENCY, 2: cycles from RAM enable/address to valid data on ram_dout_in.
- LEN_W, 11: width of burst length.
- FIFO_DEPTH, READ_LATENCY+2: output FIFO entries; must be >= READ_LATENCY+1.

Ports:
- clk_in  in  1  single clock for the block and the attached RAM port.
- rst_n_in  in  1  asynchronous active-low reset.
- req_valid_in  in  1  burst request valid.
- req_ready_out  out  1  high only in IDLE.
- req_addr_in  in  ADDR_W  first word address.
- req_len_in  in  LEN_W  number of words to read; 0 is legal.
- ram_addr_out  out  ADDR_W  RAM port address.
- ram_en_out  out  1  RAM port enable, high only on issue cycles.
- ram_regce_out  out  1  RAM output register enable, constant 1.
- ram_dout_in  in  RAM_WIDTH  RAM port read data.
- data_out  out  RAM_WIDTH  stream word (FIFO head).
- data_last_out  out  1  marks the final word of the burst.
- data_valid_out  out  1  stream valid.
- data_ready_in  in  1  stream ready.
- busy_out  out  1  high whenever state is not IDLE.

## Operation
- States are IDLE, ISSUE and DRAIN.
- IDLE:
  - req_ready_out=1.
  - On req_valid_in&&req_ready_out, latch addr and len.
  - len==0: remain in IDLE; no RAM access and no output beat.
  - Otherwise go to ISSUE.
- ISSUE:
  - Each cycle, a read issues iff inflight + fifo_count < FIFO_DEPTH. inflight is the number of issued reads not yet captured.
  - On issue: ram_en_out=1, ram_addr_out=current addr, remaining decrements, and addr advances.
  - Address advance: addr = (addr==RAM_DEPTH-1) ? 0 : addr+1. Wrap is explicit, so non-power-of-two depths are correct.
  - A READ_LATENCY-deep shift register carries {valid, last} per issue. last is set on the issue with remaining==1.
  - When the last issue occurs, go to DRAIN.
- DRAIN:
  - No issues.
  - Return to IDLE when inflight==0, the FIFO is empty and no beat is pending. That is, in the cycle after the data_last_out beat handshakes.
- Capture: when the shift-register output valid is 1, write {ram_dout_in, last} into the FIFO. The credit rule guarantees the FIFO is never full at capture.
- Output: data_valid_out = FIFO not empty. Pop on data_valid_out&&data_ready_in. data_out and data_last_out must hold stable while valid&&!ready.
- Simultaneous FIFO push and pop in one cycle: count unchanged; both operations take effect.
- RAM write port: never driven by this block.

## Timing
- Reset values: req_ready_out=1, busy_out=0, ram_en_out=0, ram_addr_out=0, ram_regce_out=1, data_valid_out=0, data_last_out=0, data_out=0. FIFO, inflight and remaining are all cleared.
- Reset mid-burst: the burst is abandoned immediately and in-flight returns are discarded. RAM contents are unaffected.
- Latency:
  - Request accepted at edge E0 → first ram_en_out in the cycle after E0.
  - First data_valid_out after edge E0+READ_LATENCY+1, i.e. 3 edges with default parameters.
- Throughput: one word per cycle sustained when data_ready_in is held high.
- Next request: the earliest accept is one cycle after the last beat handshake.
- Back-pressure: with data_ready_in low, issuing stops after FIFO_DEPTH total words are buffered or in flight. It resumes in the cycle after a pop frees a credit.
- busy_out falls in the same cycle req_ready_out rises.

## Test plan
- Burst addr=10, len=4, RAM[i]=i+100, ready=1:
  - words 110,111,112,113 on 4 consecutive cycles;
  - last only on 113;
  - first valid 3 edges after accept.
- Same burst with data_ready_in low for 6 cycles mid-burst:
  - no loss, duplication or reordering;
  - at most FIFO_DEPTH=4 reads outstanding;
  - data_out stable while stalled.
- Wrap: addr=1022, len=4, RAM_DEPTH=1024 → addresses 1022,1023,0,1 in that order.
- len=0 request: accepted, busy_out stays 0, ram_en_out never asserted, no beat.
- rst_n_in pulsed low after 2 of 8 beats:
  - all outputs reach reset values asynchronously;
  - after release, a new burst addr=0, len=2 returns exactly RAM[0], RAM[1].
- Back-to-back bursts (5,3) then (200,2) with ready=1: 5 beats with last on the 3rd, then 2 beats with last on the 2nd; second request accepted one cycle after the first last beat.
